// File: rtl/fibonachi_checker.sv
// Receive-side checker for the Fibonacci generator stream: hunts for the sequence
// start, locks after LOCK_CNT good terms, flags and counts mismatches while locked.
module fibonachi_checker #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 3,
    parameter int MISS_MAX = 2,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_count,
    output logic [7:0]       index,
    output logic             period_done
);

    localparam int MC_W = $clog2(LOCK_CNT + 1);
    localparam int MS_W = $clog2(MISS_MAX + 1);

    localparam logic [WIDTH-1:0] TERM_ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] TERM_TWO   = WIDTH'(2);
    localparam logic [WIDTH-1:0] TERM_THREE = WIDTH'(3);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  prev;
    logic [WIDTH-1:0]  exp;
    logic [MC_W-1:0]   match_cnt;
    logic [MS_W-1:0]   miss_cnt;

    logic [WIDTH:0]    sum;
    logic              wrap;
    logic              hit;
    logic [WIDTH-1:0]  adv_prev;
    logic [WIDTH-1:0]  adv_exp;
    logic [7:0]        adv_index;
    logic [MC_W-1:0]   match_inc;
    logic [MS_W-1:0]   miss_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Next model state if the current expected term is consumed. prev==0 only
    // occurs right after a wrap, so the term about to be accepted is index 0.
    always_comb begin
        sum       = {1'b0, exp} + {1'b0, prev};
        wrap      = sum[WIDTH];
        hit       = (in_data == exp);
        adv_prev  = wrap ? '0 : exp;
        adv_exp   = wrap ? TERM_ONE : sum[WIDTH-1:0];
        adv_index = (prev == '0) ? 8'd0 : index + 8'd1;
        match_inc = match_cnt + 1'b1;
        miss_inc  = miss_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HUNT;
            locked      <= 1'b0;
            err         <= 1'b0;
            err_count   <= '0;
            index       <= 8'd0;
            period_done <= 1'b0;
            match_cnt   <= '0;
            miss_cnt    <= '0;
            prev        <= '0;
            exp         <= TERM_ONE;
        end else begin
            err         <= 1'b0;
            period_done <= 1'b0;
            if (in_valid) begin
                case (state)
                    HUNT: begin
                        if (in_data == TERM_ONE) begin
                            state     <= SYNC;
                            prev      <= TERM_ONE;
                            exp       <= TERM_ONE;
                            index     <= 8'd0;
                            match_cnt <= MC_W'(1);
                        end
                    end

                    SYNC: begin
                        if (hit) begin
                            prev      <= adv_prev;
                            exp       <= adv_exp;
                            index     <= adv_index;
                            match_cnt <= match_inc;
                            if (match_inc >= MC_W'(LOCK_CNT)) begin
                                state    <= LOCKED;
                                locked   <= 1'b1;
                                miss_cnt <= '0;
                            end
                        end else if (match_cnt == MC_W'(1) && in_data == TERM_TWO) begin
                            // The seeding 1 was really the second term of the period.
                            prev      <= TERM_TWO;
                            exp       <= TERM_THREE;
                            index     <= 8'd2;
                            match_cnt <= MC_W'(2);
                            if (LOCK_CNT <= 2) begin
                                state    <= LOCKED;
                                locked   <= 1'b1;
                                miss_cnt <= '0;
                            end
                        end else if (in_data == TERM_ONE) begin
                            prev      <= TERM_ONE;
                            exp       <= TERM_ONE;
                            index     <= 8'd0;
                            match_cnt <= MC_W'(1);
                        end else begin
                            state     <= HUNT;
                            match_cnt <= '0;
                        end
                    end

                    LOCKED: begin
                        // A bad term is treated as corrupted, not dropped: the model advances.
                        prev  <= adv_prev;
                        exp   <= adv_exp;
                        index <= adv_index;
                        if (hit) begin
                            miss_cnt    <= '0;
                            period_done <= wrap;
                        end else begin
                            err       <= 1'b1;
                            err_count <= sat_inc(err_count);
                            if (miss_inc >= MS_W'(MISS_MAX)) begin
                                state     <= HUNT;
                                locked    <= 1'b0;
                                miss_cnt  <= '0;
                                match_cnt <= '0;
                            end else begin
                                miss_cnt <= miss_inc;
                            end
                        end
                    end

                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fibonachi_checker.sv
// Bench for fibonachi_checker: directed and randomized sample streams checked
// against a period-table reference model; a CNT_W=2 instance covers saturation.
module tb_fibonachi_checker;

    localparam int WIDTH    = 4;
    localparam int LOCK_CNT = 3;
    localparam int MISS_MAX = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;

    logic             locked, err, period_done;
    logic [7:0]       err_count;
    logic [7:0]       index;
    logic             locked2, err2, period_done2;
    logic [1:0]       err_count2;
    logic [7:0]       index2;

    fibonachi_checker #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .MISS_MAX(MISS_MAX), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .locked(locked), .err(err), .err_count(err_count), .index(index),
        .period_done(period_done)
    );

    fibonachi_checker #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .MISS_MAX(MISS_MAX), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .locked(locked2), .err(err2), .err_count(err_count2), .index(index2),
        .period_done(period_done2)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: the period as a table, position = index of last accepted term.
    localparam int M_HUNT = 0, M_SYNC = 1, M_LOCK = 2;
    int seq[$];
    int m_state, m_pos, m_mcnt, m_miss, m_errs;
    bit e_err, e_pd;
    int gap_max = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    endtask

    function automatic int next_term();
        return seq[(m_pos + 1) % seq.size()];
    endfunction

    task automatic model_reset();
        m_state = M_HUNT; m_pos = 0; m_mcnt = 0; m_miss = 0; m_errs = 0;
        e_err = 0; e_pd = 0;
    endtask

    task automatic model_step(input int v);
        int nxt;
        e_err = 0; e_pd = 0;
        nxt = (m_pos + 1) % seq.size();
        case (m_state)
            M_HUNT: if (v == 1) begin m_state = M_SYNC; m_pos = 0; m_mcnt = 1; end
            M_SYNC: begin
                if (v == seq[nxt]) begin m_pos = nxt; m_mcnt++; end
                else if (m_mcnt == 1 && v == seq[2]) begin m_pos = 2; m_mcnt = 2; end
                else if (v == 1) begin m_pos = 0; m_mcnt = 1; end
                else m_state = M_HUNT;
                if (m_state == M_SYNC && m_mcnt >= LOCK_CNT) begin
                    m_state = M_LOCK; m_miss = 0;
                end
            end
            default: begin
                if (v == seq[nxt]) begin
                    m_miss = 0;
                    e_pd = (nxt == seq.size() - 1);
                end else begin
                    e_err = 1; m_errs++; m_miss++;
                    if (m_miss >= MISS_MAX) m_state = M_HUNT;
                end
                m_pos = nxt;
            end
        endcase
    endtask

    task automatic check_all(input string tag);
        check({tag, ".locked"}, 32'(locked), 32'(m_state == M_LOCK));
        check({tag, ".err"}, 32'(err), 32'(e_err));
        check({tag, ".period_done"}, 32'(period_done), 32'(e_pd));
        check({tag, ".index"}, 32'(index), 32'(m_pos));
        check({tag, ".err_count"}, 32'(err_count), 32'((m_errs > 255) ? 255 : m_errs));
        check({tag, ".err_count_sat"}, 32'(err_count2), 32'((m_errs > 3) ? 3 : m_errs));
        check({tag, ".locked_sat"}, 32'(locked2), 32'(m_state == M_LOCK));
    endtask

    task automatic idle(input string tag);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 4'($urandom);
        @(posedge clk);
        #1;
        e_err = 0; e_pd = 0;
        check_all({tag, ".idle"});
    endtask

    task automatic send(input string tag, input int v);
        int g;
        g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        repeat (g) idle(tag);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 4'(v);
        @(posedge clk);
        model_step(v);
        #1;
        check_all(tag);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();
        check_all({tag, ".reset"});
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_list(input string tag, input int vals[$]);
        foreach (vals[i]) send(tag, vals[i]);
    endtask

    initial begin
        int v, r;
        seq.push_back(1);
        seq.push_back(1);
        while (seq[seq.size()-1] + seq[seq.size()-2] < (1 << WIDTH))
            seq.push_back(seq[seq.size()-1] + seq[seq.size()-2]);

        // Clean period from reset, through the wrap.
        do_reset("rst0");
        send_list("clean", '{1, 1, 2, 3, 5, 8, 13, 1, 1, 2});
        check("clean.final_index", 32'(index), 32'd2);
        check("clean.no_errors", 32'(err_count), 32'd0);

        // Mid-period start.
        do_reset("rst1");
        send_list("midstart", '{9, 5, 1, 2, 3, 5});
        check("midstart.locked", 32'(locked), 32'd1);
        check("midstart.index", 32'(index), 32'd4);

        // Single corrupted term while locked.
        send_list("corrupt1", '{8, 13, 1, 1, 2, 3, 6, 8});
        check("corrupt1.count", 32'(err_count), 32'd1);
        check("corrupt1.index", 32'(index), 32'd5);

        // Two consecutive misses drop lock; relock keeps the count.
        send_list("miss2", '{13, 1, 1, 2, 7, 7});
        check("miss2.unlocked", 32'(locked), 32'd0);
        send_list("relock", '{1, 1, 2});
        check("relock.count", 32'(err_count), 32'd3);

        // Same traffic with idle gaps of 0..4 cycles.
        do_reset("rst2");
        gap_max = 4;
        send_list("gaps", '{1, 1, 2, 3, 5, 8, 13, 1, 1, 2, 3, 6, 8, 13, 1});
        gap_max = 0;

        // Reset while locked, then a 3 that HUNT ignores.
        do_reset("rst3");
        send("after_rst", 3);
        check("after_rst.locked", 32'(locked), 32'd0);

        // Isolated errors: CNT_W=2 instance saturates at 3.
        send_list("sat_lock", '{1, 1, 2});
        for (int i = 0; i < 5; i++) begin
            send("sat_bad", (next_term() + 1) % (1 << WIDTH));
            send("sat_good", next_term());
        end
        check("sat.err_count2", 32'(err_count2), 32'd3);
        check("sat.err_count", 32'(err_count), 32'd5);
        check("sat.locked", 32'(locked), 32'd1);

        // Randomized stream: mostly correct terms with corruption, junk and gaps.
        do_reset("rst4");
        gap_max = 2;
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 15));
            if (m_state == M_HUNT && r < 8) v = 1;
            else if (r == 0) v = int'($urandom_range(0, 15));
            else if (r == 1) v = (next_term() + 3) % 16;
            else v = next_term();
            send("rand", v);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
